munoc_axi2ahb_slave_bridge: RTL and testbench

MUNOC_AXI2AHB_SLAVE_BRIDGE -- requirements
Module: munoc_axi2ahb_slave_bridge

---
 rtl/munoc_axi2ahb_slave_bridge.sv | 270 +++++++++++++++++++++++++++
 tb/tb_munoc_axi2ahb_slave_bridge.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/munoc_axi2ahb_slave_bridge.sv
// rtl/munoc_axi2ahb_slave_bridge.sv - AXI slave to single-beat AHB initiator bridge (option: MUNOC_AXI2AHB_ERROR_RESPONSE_EN)
module munoc_axi2ahb_slave_bridge #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 4
) (
    input  logic                    clk,
    input  logic                    rstnn,

    input  logic [BW_AXI_TID-1:0]   rxawid,
    input  logic [BW_ADDR-1:0]      rxawaddr,
    input  logic [7:0]              rxawlen,
    input  logic [2:0]              rxawsize,
    input  logic [1:0]              rxawburst,
    input  logic                    rxawvalid,
    output logic                    rxawready,

    input  logic [BW_DATA-1:0]      rxwdata,
    input  logic [BW_DATA/8-1:0]    rxwstrb,
    input  logic                    rxwlast,
    input  logic                    rxwvalid,
    output logic                    rxwready,

    output logic [BW_AXI_TID-1:0]   rxbid,
    output logic [1:0]              rxbresp,
    output logic                    rxbvalid,
    input  logic                    rxbready,

    input  logic [BW_AXI_TID-1:0]   rxarid,
    input  logic [BW_ADDR-1:0]      rxaraddr,
    input  logic [7:0]              rxarlen,
    input  logic [2:0]              rxarsize,
    input  logic [1:0]              rxarburst,
    input  logic                    rxarvalid,
    output logic                    rxarready,

    output logic [BW_AXI_TID-1:0]   rxrid,
    output logic [BW_DATA-1:0]      rxrdata,
    output logic [1:0]              rxrresp,
    output logic                    rxrlast,
    output logic                    rxrvalid,
    input  logic                    rxrready,

    output logic [BW_ADDR-1:0]      shaddr,
    output logic [2:0]              shburst,
    output logic                    shmasterlock,
    output logic [3:0]              shprot,
    output logic [2:0]              shsize,
    output logic [1:0]              shtrans,
    output logic [BW_DATA-1:0]      shwdata,
    output logic                    shwrite,

    input  logic [BW_DATA-1:0]      shrdata,
    input  logic                    shready,
    input  logic                    shresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] BURST_FIXED   = 2'b00;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        RRESP
    } state_t;

    state_t state;
    state_t state_next;

    logic                  prio_read;
    logic [BW_AXI_TID-1:0] id_q;
    logic [BW_ADDR-1:0]    addr_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [BW_DATA-1:0]    wdata_q;
    logic [BW_DATA-1:0]    rdata_q;
    logic [1:0]            rresp_q;

    logic                  grant_aw;
    logic                  grant_ar;
    logic                  w_hs;
    logic                  b_hs;
    logic                  r_hs;
    logic                  wbeat_done;
    logic                  rbeat_done;
    logic                  last_beat;
    logic                  beat_err;
    logic [BW_ADDR-1:0]    addr_next;
    logic                  unused_inputs;

`ifdef MUNOC_AXI2AHB_ERROR_RESPONSE_EN
    assign beat_err      = shresp;
    assign unused_inputs = ^{rxwstrb, rxwlast};
`else
    assign beat_err      = 1'b0;
    assign unused_inputs = ^{rxwstrb, rxwlast, shresp};
`endif

    // Grant one request channel in IDLE; a tie goes to the side the priority bit favours.
    // Gated by rstnn so no ready leaks out while reset is held.
    always_comb begin
        grant_aw = 1'b0;
        grant_ar = 1'b0;
        if (rstnn && state == IDLE) begin
            if (rxawvalid && rxarvalid) begin
                grant_aw = ~prio_read;
                grant_ar = prio_read;
            end else begin
                grant_aw = rxawvalid;
                grant_ar = rxarvalid;
            end
        end
    end

    assign w_hs       = (state == WADDR) && rxwvalid;
    assign b_hs       = (state == WRESP) && rxbready;
    assign r_hs       = (state == RRESP) && rxrready;
    assign wbeat_done = (state == WDATA) && shready;
    assign rbeat_done = (state == RDATA) && shready;
    assign last_beat  = (cnt_q == 8'd0);
    assign addr_next  = (burst_q == BURST_FIXED) ? addr_q : addr_q + (BW_ADDR'(1) << size_q);

    assign rxawready  = grant_aw;
    assign rxarready  = grant_ar;
    assign rxwready   = w_hs;

    assign rxbvalid   = (state == WRESP);
    assign rxbid      = id_q;
    assign rxbresp    = err_q ? RESP_SLVERR : RESP_OKAY;

    assign rxrvalid   = (state == RRESP);
    assign rxrid      = id_q;
    assign rxrdata    = rdata_q;
    assign rxrresp    = rresp_q;
    assign rxrlast    = (state == RRESP) && last_beat;

    // Address phase only in the W-handshake cycle of WADDR or in RADDR; data phases show IDLE.
    assign shtrans      = (w_hs || state == RADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign shwrite      = (state == WADDR) || (state == WDATA);
    assign shaddr       = addr_q;
    assign shwdata      = wdata_q;
    assign shsize       = size_q;
    assign shburst      = 3'b000;
    assign shprot       = 4'b0011;
    assign shmasterlock = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one AHB beat at a time, beat counter decides when the burst ends.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_aw) begin
                    state_next = WADDR;
                end else if (grant_ar) begin
                    state_next = RADDR;
                end
            end
            WADDR: begin
                if (w_hs) begin
                    state_next = WDATA;
                end
            end
            WDATA: begin
                if (shready) begin
                    state_next = last_beat ? WRESP : WADDR;
                end
            end
            WRESP: begin
                if (rxbready) begin
                    state_next = IDLE;
                end
            end
            RADDR: begin
                state_next = RDATA;
            end
            RDATA: begin
                if (shready) begin
                    state_next = RRESP;
                end
            end
            RRESP: begin
                if (rxrready) begin
                    state_next = last_beat ? IDLE : RADDR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction context, beat data and arbitration priority.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            prio_read <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (grant_aw) begin
                id_q    <= rxawid;
                addr_q  <= rxawaddr;
                cnt_q   <= rxawlen;
                size_q  <= rxawsize;
                burst_q <= rxawburst;
                err_q   <= 1'b0;
            end else if (grant_ar) begin
                id_q    <= rxarid;
                addr_q  <= rxaraddr;
                cnt_q   <= rxarlen;
                size_q  <= rxarsize;
                burst_q <= rxarburst;
                err_q   <= 1'b0;
            end

            if (w_hs) begin
                wdata_q <= rxwdata;
            end

            if (wbeat_done) begin
                if (beat_err) begin
                    err_q <= 1'b1;
                end
                if (!last_beat) begin
                    cnt_q  <= cnt_q - 8'd1;
                    addr_q <= addr_next;
                end
            end

            if (rbeat_done) begin
                rdata_q <= shrdata;
                rresp_q <= beat_err ? RESP_SLVERR : RESP_OKAY;
            end

            if (r_hs && !last_beat) begin
                cnt_q  <= cnt_q - 8'd1;
                addr_q <= addr_next;
            end

            if (b_hs || (r_hs && last_beat)) begin
                prio_read <= ~prio_read;
            end
        end
    end

endmodule

// File: tb/tb_munoc_axi2ahb_slave_bridge.sv
// tb/tb_munoc_axi2ahb_slave_bridge.sv - testbench for munoc_axi2ahb_slave_bridge
module tb_munoc_axi2ahb_slave_bridge;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic [3:0]  rxawid = '0;
    logic [31:0] rxawaddr = '0;
    logic [7:0]  rxawlen = '0;
    logic [2:0]  rxawsize = '0;
    logic [1:0]  rxawburst = '0;
    logic        rxawvalid = 1'b0;
    logic        rxawready;
    logic [31:0] rxwdata = '0;
    logic [3:0]  rxwstrb = 4'hF;
    logic        rxwlast = 1'b0;
    logic        rxwvalid = 1'b0;
    logic        rxwready;
    logic [3:0]  rxbid;
    logic [1:0]  rxbresp;
    logic        rxbvalid;
    logic        rxbready = 1'b0;
    logic [3:0]  rxarid = '0;
    logic [31:0] rxaraddr = '0;
    logic [7:0]  rxarlen = '0;
    logic [2:0]  rxarsize = '0;
    logic [1:0]  rxarburst = '0;
    logic        rxarvalid = 1'b0;
    logic        rxarready;
    logic [3:0]  rxrid;
    logic [31:0] rxrdata;
    logic [1:0]  rxrresp;
    logic        rxrlast;
    logic        rxrvalid;
    logic        rxrready = 1'b0;
    logic [31:0] shaddr;
    logic [2:0]  shburst;
    logic        shmasterlock;
    logic [3:0]  shprot;
    logic [2:0]  shsize;
    logic [1:0]  shtrans;
    logic [31:0] shwdata;
    logic        shwrite;
    logic [31:0] shrdata;
    logic        shready;
    logic        shresp;

    int checks = 0;
    int errors = 0;

    bit prio_write = 1'b1;

    int  slv_waits = 0;
    int  slv_err_beat = -1;
    int  slv_beat = 0;
    int  xfers = 0;
    bit  in_data = 1'b0;
    bit  completing = 1'b0;
    bit  cur_err = 1'b0;
    bit  cur_write = 1'b0;
    int  wl = 0;
    logic [31:0] s_addr_q[$];
    bit          s_write_q[$];
    logic [2:0]  s_size_q[$];
    logic [31:0] s_wdata_q[$];
    logic [31:0] s_rdata_q[$];
    logic [31:0] wplan[0:15];

    munoc_axi2ahb_slave_bridge #(
        .BW_ADDR(32),
        .BW_DATA(32),
        .BW_AXI_TID(4)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .rxawid(rxawid), .rxawaddr(rxawaddr), .rxawlen(rxawlen), .rxawsize(rxawsize),
        .rxawburst(rxawburst), .rxawvalid(rxawvalid), .rxawready(rxawready),
        .rxwdata(rxwdata), .rxwstrb(rxwstrb), .rxwlast(rxwlast), .rxwvalid(rxwvalid), .rxwready(rxwready),
        .rxbid(rxbid), .rxbresp(rxbresp), .rxbvalid(rxbvalid), .rxbready(rxbready),
        .rxarid(rxarid), .rxaraddr(rxaraddr), .rxarlen(rxarlen), .rxarsize(rxarsize),
        .rxarburst(rxarburst), .rxarvalid(rxarvalid), .rxarready(rxarready),
        .rxrid(rxrid), .rxrdata(rxrdata), .rxrresp(rxrresp), .rxrlast(rxrlast),
        .rxrvalid(rxrvalid), .rxrready(rxrready),
        .shaddr(shaddr), .shburst(shburst), .shmasterlock(shmasterlock), .shprot(shprot),
        .shsize(shsize), .shtrans(shtrans), .shwdata(shwdata), .shwrite(shwrite),
        .shrdata(shrdata), .shready(shready), .shresp(shresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // AHB slave model: drives ready/resp at negedge, samples address phases 2 time units before posedge.
    initial begin
        shready = 1'b1;
        shresp  = 1'b0;
        shrdata = '0;
        forever begin
            @(negedge clk);
            if (!rstnn) begin
                in_data = 1'b0; completing = 1'b0; shready = 1'b1; shresp = 1'b0;
            end else if (in_data) begin
                if (wl > 0) begin
                    shready = 1'b0; shresp = cur_err && (wl == 1); wl--;
                end else begin
                    shready = 1'b1; shresp = cur_err; completing = 1'b1;
                    if (!cur_write) begin
                        shrdata = $urandom;
                        s_rdata_q.push_back(shrdata);
                    end
                end
            end else begin
                shready = 1'b1; shresp = 1'b0;
            end
            #3;
            if (completing) begin
                if (cur_write) s_wdata_q.push_back(shwdata);
                in_data = 1'b0; completing = 1'b0;
            end
            if (rstnn && shtrans == 2'b10) begin
                checks++;
                if (in_data || shburst !== 3'b000 || shprot !== 4'b0011 || shmasterlock !== 1'b0) begin
                    errors++;
                    $display("FAIL ahb_xfer_attr: busy=%0d burst=%0h prot=%0h lock=%0b, required busy=0 burst=0 prot=3 lock=0",
                             in_data, shburst, shprot, shmasterlock);
                end
                s_addr_q.push_back(shaddr);
                s_write_q.push_back(shwrite);
                s_size_q.push_back(shsize);
                in_data = 1'b1; wl = slv_waits; cur_err = (slv_beat == slv_err_beat);
                cur_write = shwrite; slv_beat++; xfers++;
            end else if (rstnn && shtrans !== 2'b00) begin
                checks++; errors++;
                $display("FAIL ahb_htrans: shtrans=%0h, required 0 or 2", shtrans);
            end
        end
    end

    task automatic clear_slave();
        s_addr_q.delete(); s_write_q.delete(); s_size_q.delete();
        s_wdata_q.delete(); s_rdata_q.delete();
        slv_beat = 0;
    endtask

    task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0; bit hs = 1'b0;
        clear_slave();
        rxawid = id; rxawaddr = addr; rxawlen = len; rxawsize = size; rxawburst = burst; rxawvalid = 1'b1;
        while (!hs && n < 200) begin #3; hs = rxawready; @(negedge clk); n++; end
        rxawvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL aw_handshake: rxawready=0 after %0d cycles, required 1", n); end
    endtask

    task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0; bit hs = 1'b0;
        clear_slave();
        rxarid = id; rxaraddr = addr; rxarlen = len; rxarsize = size; rxarburst = burst; rxarvalid = 1'b1;
        while (!hs && n < 200) begin #3; hs = rxarready; @(negedge clk); n++; end
        rxarvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL ar_handshake: rxarready=0 after %0d cycles, required 1", n); end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input int k);
        return (burst == 2'b00) ? addr : addr + (32'(k) << size);
    endfunction

    task automatic wb_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n; bit hs; logic [3:0] bid; logic [1:0] bresp; logic [1:0] exp_resp;
        rxbready = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            rxwdata = wplan[k]; rxwlast = (k == int'(len)); rxwvalid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 200) begin #3; hs = rxwready; @(negedge clk); n++; end
            rxwvalid = 1'b0;
            if (!hs) begin
                checks++; errors++;
                $display("FAIL w_handshake: beat %0d rxwready=0 after %0d cycles, required 1", k, n);
                return;
            end
        end
        rxbready = 1'b1; n = 0; hs = 1'b0; bid = '0; bresp = '0;
        while (!hs && n < 200) begin
            #3; hs = rxbvalid;
            if (hs) begin bid = rxbid; bresp = rxbresp; end
            @(negedge clk); n++;
        end
        rxbready = 1'b0;
`ifdef MUNOC_AXI2AHB_ERROR_RESPONSE_EN
        exp_resp = (slv_err_beat >= 0 && slv_err_beat <= int'(len)) ? 2'b10 : 2'b00;
`else
        exp_resp = 2'b00;
`endif
        checks++;
        if (!hs || bid !== id || bresp !== exp_resp) begin
            errors++;
            $display("FAIL b_response: valid=%0b id=%0h resp=%0h, required valid=1 id=%0h resp=%0h", hs, bid, bresp, id, exp_resp);
        end
        checks++;
        if (s_addr_q.size() != int'(len) + 1 || s_wdata_q.size() != int'(len) + 1) begin
            errors++;
            $display("FAIL w_beat_count: addr phases=%0d data phases=%0d, required %0d", s_addr_q.size(), s_wdata_q.size(), int'(len) + 1);
        end else begin
            for (int k = 0; k <= int'(len); k++) begin
                checks++;
                if (s_addr_q[k] !== beat_addr(addr, size, burst, k) || s_write_q[k] !== 1'b1 ||
                    s_size_q[k] !== size || s_wdata_q[k] !== wplan[k]) begin
                    errors++;
                    $display("FAIL w_beat%0d: addr=%h write=%0b size=%0d data=%h, required addr=%h write=1 size=%0d data=%h",
                             k, s_addr_q[k], s_write_q[k], s_size_q[k], s_wdata_q[k], beat_addr(addr, size, burst, k), size, wplan[k]);
                end
            end
        end
        prio_write = !prio_write;
    endtask

    task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int hold_beat, input int hold_cycles);
        int n; int x0; logic [31:0] d; logic [1:0] exp_resp;
        rxrready = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            n = 0;
            #3;
            while (!rxrvalid && n < 200) begin @(negedge clk); #3; n++; end
            if (!rxrvalid || s_rdata_q.size() <= k) begin
                checks++; errors++;
                $display("FAIL r_valid: beat %0d rxrvalid=%0b after %0d cycles, required 1", k, rxrvalid, n);
                return;
            end
            checks++;
            if (n != 2 + slv_waits) begin
                errors++;
                $display("FAIL r_latency: beat %0d valid after %0d cycles, required %0d", k, n, 2 + slv_waits);
            end
`ifdef MUNOC_AXI2AHB_ERROR_RESPONSE_EN
            exp_resp = (k == slv_err_beat) ? 2'b10 : 2'b00;
`else
            exp_resp = 2'b00;
`endif
            d = s_rdata_q[k];
            checks++;
            if (rxrid !== id || rxrdata !== d || rxrlast !== (k == int'(len)) || rxrresp !== exp_resp) begin
                errors++;
                $display("FAIL r_beat%0d: id=%0h data=%h last=%0b resp=%0h, required id=%0h data=%h last=%0b resp=%0h",
                         k, rxrid, rxrdata, rxrlast, rxrresp, id, d, (k == int'(len)), exp_resp);
            end
            if (k == hold_beat) begin
                for (int h = 0; h < hold_cycles; h++) begin
                    x0 = xfers;
                    @(negedge clk); #3;
                    checks++;
                    if (rxrvalid !== 1'b1 || rxrdata !== d || xfers != x0) begin
                        errors++;
                        $display("FAIL r_hold: cycle %0d valid=%0b data=%h new_xfers=%0d, required valid=1 data=%h new_xfers=0",
                                 h, rxrvalid, rxrdata, xfers - x0, d);
                    end
                end
            end
            @(negedge clk); rxrready = 1'b1;
            @(negedge clk); rxrready = 1'b0;
        end
        checks++;
        if (s_addr_q.size() != int'(len) + 1) begin
            errors++;
            $display("FAIL r_beat_count: addr phases=%0d, required %0d", s_addr_q.size(), int'(len) + 1);
        end else begin
            for (int k = 0; k <= int'(len); k++) begin
                checks++;
                if (s_addr_q[k] !== beat_addr(addr, size, burst, k) || s_write_q[k] !== 1'b0 || s_size_q[k] !== size) begin
                    errors++;
                    $display("FAIL r_addr%0d: addr=%h write=%0b size=%0d, required addr=%h write=0 size=%0d",
                             k, s_addr_q[k], s_write_q[k], s_size_q[k], beat_addr(addr, size, burst, k), size);
                end
            end
        end
        prio_write = !prio_write;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({rxawready, rxarready, rxwready, rxbvalid, rxrvalid, rxrlast} !== 6'b0) begin
            errors++;
            $display("FAIL %s_handshakes: aw=%0b ar=%0b w=%0b b=%0b r=%0b last=%0b, required all 0",
                     tag, rxawready, rxarready, rxwready, rxbvalid, rxrvalid, rxrlast);
        end
        checks++;
        if (shtrans !== 2'b00) begin
            errors++; $display("FAIL %s_shtrans: %0h, required 0", tag, shtrans);
        end
        checks++;
        if (shaddr !== 32'h0 || shwdata !== 32'h0 || rxrdata !== 32'h0 || rxbid !== 4'h0 || rxrid !== 4'h0 ||
            rxbresp !== 2'b00 || rxrresp !== 2'b00) begin
            errors++;
            $display("FAIL %s_values: shaddr=%h shwdata=%h rdata=%h bid=%0h rid=%0h bresp=%0h rresp=%0h, required all 0",
                     tag, shaddr, shwdata, rxrdata, rxbid, rxrid, rxbresp, rxrresp);
        end
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        rxawvalid = 1'b1; rxarvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rxawvalid = 1'b0; rxarvalid = 1'b0; rstnn = 1'b1;
        prio_write = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        slv_waits = 0; slv_err_beat = -1;
        wplan[0] = 32'hDEADBEEF;
        aw_issue(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        wb_phase(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
    endtask

    task automatic test_incr_read_waits();
        slv_waits = 1; slv_err_beat = -1;
        ar_issue(4'd5, 32'h200, 8'd3, 3'd2, 2'b01);
        r_phase(4'd5, 32'h200, 8'd3, 3'd2, 2'b01, -1, 0);
    endtask

    task automatic tie_issue(input logic [3:0] wid, input logic [31:0] waddr,
                             input logic [3:0] rid, input logic [31:0] raddr);
        clear_slave();
        rxawid = wid; rxawaddr = waddr; rxawlen = 8'd0; rxawsize = 3'd2; rxawburst = 2'b01; rxawvalid = 1'b1;
        rxarid = rid; rxaraddr = raddr; rxarlen = 8'd0; rxarsize = 3'd2; rxarburst = 2'b01; rxarvalid = 1'b1;
        #3;
        checks++;
        if (rxawready !== prio_write || rxarready !== !prio_write) begin
            errors++;
            $display("FAIL tie_grant: awready=%0b arready=%0b, required awready=%0b arready=%0b",
                     rxawready, rxarready, prio_write, !prio_write);
        end
        @(negedge clk);
        rxawvalid = 1'b0;
    endtask

    task automatic test_arbitration();
        slv_waits = 0; slv_err_beat = -1;
        wplan[0] = $urandom;
        tie_issue(4'd1, 32'h40, 4'd2, 32'h80);
        wb_phase(4'd1, 32'h40, 8'd0, 3'd2, 2'b01);
        ar_issue(4'd2, 32'h80, 8'd0, 3'd2, 2'b01);
        r_phase(4'd2, 32'h80, 8'd0, 3'd2, 2'b01, -1, 0);
        wplan[0] = $urandom;
        tie_issue(4'd9, 32'h44, 4'd10, 32'h84);
        wb_phase(4'd9, 32'h44, 8'd0, 3'd2, 2'b01);
        ar_issue(4'd10, 32'h84, 8'd0, 3'd2, 2'b01);
        r_phase(4'd10, 32'h84, 8'd0, 3'd2, 2'b01, -1, 0);
    endtask

    task automatic test_error_response();
        slv_waits = 1; slv_err_beat = 1;
        for (int k = 0; k < 3; k++) wplan[k] = $urandom;
        aw_issue(4'd6, 32'h1000, 8'd2, 3'd2, 2'b01);
        wb_phase(4'd6, 32'h1000, 8'd2, 3'd2, 2'b01);
        ar_issue(4'd7, 32'h2000, 8'd2, 3'd2, 2'b01);
        r_phase(4'd7, 32'h2000, 8'd2, 3'd2, 2'b01, -1, 0);
        slv_err_beat = -1;
        wplan[0] = $urandom;
        aw_issue(4'd8, 32'h1010, 8'd0, 3'd2, 2'b01);
        wb_phase(4'd8, 32'h1010, 8'd0, 3'd2, 2'b01);
    endtask

    task automatic test_fixed_hold_and_wrap();
        slv_waits = 0; slv_err_beat = -1;
        ar_issue(4'd4, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b00);
        r_phase(4'd4, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b00, 0, 5);
        wplan[0] = $urandom; wplan[1] = $urandom;
        aw_issue(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
        wb_phase(4'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    endtask

    task automatic test_random();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        for (int t = 0; t < 12; t++) begin
            slv_waits = $urandom_range(0, 2); slv_err_beat = -1;
            id = 4'($urandom); len = 8'($urandom_range(0, 3)); size = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            addr = $urandom & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k <= int'(len); k++) wplan[k] = $urandom;
                aw_issue(id, addr, len, size, burst);
                wb_phase(id, addr, len, size, burst);
            end else begin
                ar_issue(id, addr, len, size, burst);
                r_phase(id, addr, len, size, burst, $urandom_range(0, int'(len)), $urandom_range(0, 3));
            end
        end
    endtask

    task automatic test_reset_midburst();
        int n = 0; bit hs = 1'b0; int bseen = 0;
        slv_waits = 4; slv_err_beat = -1;
        aw_issue(4'd7, 32'h300, 8'd0, 3'd2, 2'b01);
        rxwdata = 32'hA5A5_1234; rxwvalid = 1'b1;
        while (!hs && n < 200) begin #3; hs = rxwready; @(negedge clk); n++; end
        rxwvalid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (shwdata !== 32'hA5A5_1234 || shaddr !== 32'h300) begin
            errors++;
            $display("FAIL midburst_pre: shwdata=%h shaddr=%h, required A5A51234 and 00000300", shwdata, shaddr);
        end
        rxawvalid = 1'b1; rxawid = 4'hF; rxarvalid = 1'b1; rxbready = 1'b1; rxrready = 1'b1;
        rstnn = 1'b0;
        #1;
        check_reset_outputs("midburst");
        @(negedge clk);
        @(negedge clk);
        rxawvalid = 1'b0; rxarvalid = 1'b0; rxbready = 1'b0; rxrready = 1'b0;
        rstnn = 1'b1;
        prio_write = 1'b1;
        rxbready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (rxbvalid || rxrvalid) bseen++;
            @(negedge clk);
        end
        rxbready = 1'b0;
        checks++;
        if (bseen != 0) begin
            errors++; $display("FAIL midburst_abandon: response valid for %0d cycles, required 0", bseen);
        end
        slv_waits = 0;
        wplan[0] = 32'h0BAD_F00D;
        aw_issue(4'd1, 32'h304, 8'd0, 3'd2, 2'b01);
        wb_phase(4'd1, 32'h304, 8'd0, 3'd2, 2'b01);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr_read_waits();
        test_arbitration();
        test_error_response();
        test_fixed_hold_and_wrap();
        test_random();
        test_reset_midburst();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
